ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Sequential arbiter that shares the single system RAM port between NREQ cache requesters: icache0, dcache0, icache1, dcache1 in index order. It sits between the caches and the memory controller's RAM port and performs grant selection, transfer sequencing and `ramstate` handshaking. It guarantees round-robin fairness with an aging override, and allows short multi-word bursts so block fills do not interleave.

## Interface
- NREQ, 4, number of requesters (index 0..NREQ-1).
- MAXBURST, 2, maximum words transferred per grant before forced release.
- STARVE, 8, age threshold in cycles that triggers the starvation override.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- req_ren  in  NREQ  per-requester read request.
- req_wen  in  NREQ  per-requester write request.
- req_addr  in  NREQ x 32  per-requester word address.
- req_store  in  NREQ x 32  per-requester write data.
- req_wait  out  NREQ  per-requester wait; 0 for exactly one cycle per completed word.
- req_load  out  NREQ x 32  per-requester read data; valid only when the matching req_wait is 0.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.
- grant_valid  out  1  a transfer is owned.
- grant_id  out  $clog2(NREQ)  current owner; holds its last value while idle.
- err  out  1  one-cycle pulse on RAM ERROR.

## Operation
- States: IDLE, XFER.
- Request rule: requester i is active when req_ren[i] or req_wen[i] is asserted. If both are asserted, the write wins and ramREN stays 0.
- IDLE:
  - If any requester is active, select one, latch owner, reset the beat count to 0, and go to XFER.
  - RAM strobes are 0 in IDLE.
- Selection:
  - If any active requester has age >= STARVE, the lowest such index wins.
  - Otherwise, scan from rr_ptr upward with wrap and pick the first active requester.
- Aging:
  - Each cycle, a requester that is active and not the owner increments its age, saturating at 15.
  - A requester's age clears when it is granted or when it is inactive.
- XFER:
  - ramaddr = req_addr[owner] and ramstore = req_store[owner], driven live.
  - ramREN and ramWEN follow the owner's request bits.
- Word completion: a word completes when ramstate is ACCESS. On that cycle:
  - req_wait[owner] is 0.
  - req_load[owner] = ramload when reading.
  - The beat count increments.
- After a completed word:
  - If the owner is still active and beat+1 < MAXBURST, stay in XFER for the next word at the owner's new address.
  - Otherwise go to IDLE and set rr_ptr = (owner+1) mod NREQ.
- Abort: if the owner drops its request in XFER before ACCESS, go to IDLE with no handshake. rr_ptr advances as for a normal release.
- ERROR: ramstate ERROR in XFER pulses err, keeps req_wait[owner] at 1, goes to IDLE and advances rr_ptr.
- Non-owners: req_wait stays 1 and req_load stays 0 at all times.

## Timing
- Reset values: state IDLE, rr_ptr 0, all ages 0, beat 0, req_wait all 1, req_load all 0, ramREN/ramWEN 0, ramaddr/ramstore 0, grant_valid 0, grant_id 0, err 0.
- Reset mid-XFER drops the RAM strobes asynchronously. No partial handshake is emitted.
- Grant latency: a request seen in IDLE at edge N puts RAM strobes on the bus from cycle N+1.
- Turnaround: at least one IDLE cycle between consecutive grants. Back-to-back owners are never strobed in adjacent cycles.
- Within a burst, the next word is strobed in the cycle after ACCESS, with no IDLE gap.
- Simultaneous events:
  - A new request arriving in the same cycle as a release is evaluated in the following IDLE cycle.
  - Starvation override beats round-robin.
  - A tie among starved requesters goes to the lowest index.
- Latency with a fixed k-cycle RAM: k+1 cycles from request to first req_wait=0.

## Test plan
- Single read: req_ren[1]=1, addr 0x40, RAM returns 0xDEADBEEF after 2 BUSY cycles. Required: ramREN the cycle after the request; req_wait[1]=0 with req_load[1]=0xDEADBEEF on the ACCESS cycle; then IDLE; rr_ptr=2.
- Contention: all four requesters request continuously for single words. Required grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Burst: requester 3 reads 0x100 then 0x104 while holding req_ren. Required: 2 words with no gap, forced release after word 2; a pending requester 0 is granted next.
- Starvation: preset rr_ptr so requester 2 loses for 8 cycles while 0 and 1 keep re-requesting. Required: requester 2 granted once age reaches 8, ahead of round-robin order.
- Abort/ERROR: owner drops req before ACCESS -> IDLE with no req_wait pulse. ramstate=ERROR -> err=1 for 1 cycle, req_wait stays 1, next requester is granted.
- Reset mid-XFER: assert nRST=0 during BUSY. Required: ramREN=0 immediately; all outputs at reset values; first post-reset grant goes to index 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares the single system RAM port among NREQ cache requesters. Owners are chosen
// round-robin, aged requesters override that order, and an owner may burst up to MAXBURST words.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;
endpackage

module ram_port_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 2,
    parameter int STARVE   = 8
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NREQ-1:0]         req_ren,
    input  logic [NREQ-1:0]         req_wen,
    input  logic [NREQ-1:0][31:0]   req_addr,
    input  logic [NREQ-1:0][31:0]   req_store,
    output logic [NREQ-1:0]         req_wait,
    output logic [NREQ-1:0][31:0]   req_load,
    output logic                    ramREN,
    output logic                    ramWEN,
    output logic [31:0]             ramaddr,
    output logic [31:0]             ramstore,
    input  logic [31:0]             ramload,
    input  ramstate_t               ramstate,
    output logic                    grant_valid,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    err
);
    localparam int              IDW        = $clog2(NREQ);
    localparam int              BW         = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [3:0]      AGE_MAX    = 4'd15;
    localparam logic [3:0]      STARVE_AGE = 4'(STARVE);
    localparam logic [BW-1:0]   LAST_BEAT  = BW'(MAXBURST - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state;
    logic [IDW-1:0]       owner;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       pick;
    logic [IDW-1:0]       scan_idx;
    logic [IDW-1:0]       next_ptr;
    logic [BW-1:0]        beat;
    logic [NREQ-1:0][3:0] age;
    logic [NREQ-1:0]      active;
    logic                 any_active;
    logic                 xfer;
    logic                 done;
    logic                 own_active;
    logic                 own_wr;
    logic                 own_rd;

    assign active     = req_ren | req_wen;
    assign any_active = |active;
    assign xfer       = (state == XFER);
    assign own_active = active[owner];
    assign own_wr     = req_wen[owner];
    assign own_rd     = req_ren[owner] & ~own_wr;
    assign done       = xfer && (ramstate == ACCESS);
    assign next_ptr   = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // Both scans run high-to-low so the last hit is the winner: the first active
    // index at or after rr_ptr, then overridden by the lowest starved index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pick     = rr_ptr;
        scan_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (active[scan_idx]) pick = scan_idx;
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (active[i] && (age[i] >= STARVE_AGE)) pick = IDW'(i);
        end
    end

    always_comb begin
        req_wait = '1;
        req_load = '0;
        if (done) begin
            req_wait[owner] = 1'b0;
            if (own_rd) req_load[owner] = ramload;
        end
    end

    // The bus is driven straight from the owner's live request so each burst beat
    // picks up the owner's new address without an extra register stage.
    assign ramREN   = xfer && own_rd;
    assign ramWEN   = xfer && own_wr;
    assign ramaddr  = xfer ? req_addr[owner]  : '0;
    assign ramstore = xfer ? req_store[owner] : '0;
    assign err      = xfer && (ramstate == ERROR);
    assign grant_id = owner;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the later age clear cleanly overrides the increment.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            beat        <= '0;
            age         <= '0;
            grant_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!active[i])
                    age[i] <= '0;
                else if (!(xfer && (owner == IDW'(i))) && (age[i] != AGE_MAX))
                    age[i] <= age[i] + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (any_active) begin
                        age[pick]   <= '0;
                        owner       <= pick;
                        beat        <= '0;
                        grant_valid <= 1'b1;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if ((ramstate == ERROR) || (!done && !own_active)) begin
                        rr_ptr      <= next_ptr;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (done) begin
                        beat <= beat + 1'b1;
                        if (!(own_active && (beat < LAST_BEAT))) begin
                            rr_ptr      <= next_ptr;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a per-cycle vector table covers single reads,
// aborts, bursts, RAM errors and contention; hand sequences cover aging and reset.
module tb_ram_port_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ = 4;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic [NREQ-1:0]       req_ren, req_wen, req_wait;
    logic [NREQ-1:0][31:0] req_addr, req_store, req_load;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    ramstate_t             ramstate;
    logic                  grant_valid;
    logic [1:0]            grant_id;
    logic                  err;

    int n_checks = 0;
    int n_errors = 0;

    // ctl = {req_wait[3:0], ramREN, ramWEN, grant_valid, grant_id[1:0], err}
    typedef struct {
        logic [3:0]  ren;
        logic [3:0]  wen;
        ramstate_t   rs;
        logic [31:0] a3;
        logic [31:0] ld;
        logic [9:0]  ctl;
    } vec_t;

    vec_t vecs[$];

    ram_port_arbiter dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req_ren    (req_ren),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_store  (req_store),
        .req_wait   (req_wait),
        .req_load   (req_load),
        .ramREN     (ramREN),
        .ramWEN     (ramWEN),
        .ramaddr    (ramaddr),
        .ramstore   (ramstore),
        .ramload    (ramload),
        .ramstate   (ramstate),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [3:0] ren, input logic [3:0] wen, input ramstate_t rs,
                                input logic [31:0] a3, input logic [31:0] ld, input logic [9:0] ctl);
        vec_t v;
        v.ren = ren; v.wen = wen; v.rs = rs; v.a3 = a3; v.ld = ld; v.ctl = ctl;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] ren, input ramstate_t rs);
        @(negedge CLK);
        req_ren  = ren;
        req_wen  = 4'b0000;
        ramstate = rs;
        ramload  = 32'h0;
        #1;
    endtask

    function automatic logic [9:0] ctl_now();
        return {req_wait, ramREN, ramWEN, grant_valid, grant_id, err};
    endfunction

    initial begin
        logic [9:0]            ec;
        logic [1:0]            gid;
        logic [63:0]           exp_bus;
        logic [NREQ-1:0][31:0] exp_load;

        // single read on 1 with two BUSY cycles, second beat aborted by the requester
        vecs.push_back(mk(4'b0010, 4'b0000, FREE,   32'h100, 32'h0,        10'b1111_00_0_00_0));
        vecs.push_back(mk(4'b0010, 4'b0000, BUSY,   32'h100, 32'h0,        10'b1111_10_1_01_0));
        vecs.push_back(mk(4'b0010, 4'b0000, BUSY,   32'h100, 32'h0,        10'b1111_10_1_01_0));
        vecs.push_back(mk(4'b0010, 4'b0000, ACCESS, 32'h100, 32'hDEADBEEF, 10'b1101_10_1_01_0));
        vecs.push_back(mk(4'b0000, 4'b0000, FREE,   32'h100, 32'h0,        10'b1111_00_1_01_0));
        // rr_ptr=2 picks 2 over 0; 2 aborts before ACCESS
        vecs.push_back(mk(4'b0101, 4'b0000, FREE,   32'h100, 32'h0,        10'b1111_00_0_01_0));
        vecs.push_back(mk(4'b0101, 4'b0000, BUSY,   32'h100, 32'h0,        10'b1111_10_1_10_0));
        vecs.push_back(mk(4'b0001, 4'b0000, BUSY,   32'h100, 32'h0,        10'b1111_00_1_10_0));
        vecs.push_back(mk(4'b0000, 4'b0000, FREE,   32'h100, 32'h0,        10'b1111_00_0_10_0));
        // burst on 3 (0x100, 0x104) with 0 pending, forced release, then 0
        vecs.push_back(mk(4'b1100, 4'b0000, FREE,   32'h100, 32'h0,        10'b1111_00_0_10_0));
        vecs.push_back(mk(4'b1001, 4'b0000, BUSY,   32'h100, 32'h0,        10'b1111_10_1_11_0));
        vecs.push_back(mk(4'b1001, 4'b0000, ACCESS, 32'h100, 32'h11111111, 10'b0111_10_1_11_0));
        vecs.push_back(mk(4'b1001, 4'b0000, ACCESS, 32'h104, 32'h22222222, 10'b0111_10_1_11_0));
        vecs.push_back(mk(4'b1001, 4'b0000, FREE,   32'h108, 32'h0,        10'b1111_00_0_11_0));
        vecs.push_back(mk(4'b1001, 4'b0000, ACCESS, 32'h108, 32'h33333333, 10'b1110_10_1_00_0));
        vecs.push_back(mk(4'b1000, 4'b0000, FREE,   32'h108, 32'h0,        10'b1111_00_1_00_0));
        // 1 reads and writes at once (write wins), RAM reports ERROR, then 3 is served
        vecs.push_back(mk(4'b1010, 4'b0010, FREE,   32'h108, 32'h0,        10'b1111_00_0_00_0));
        vecs.push_back(mk(4'b1010, 4'b0010, BUSY,   32'h108, 32'h0,        10'b1111_01_1_01_0));
        vecs.push_back(mk(4'b1010, 4'b0010, ERROR,  32'h108, 32'h0,        10'b1111_01_1_01_1));
        vecs.push_back(mk(4'b1000, 4'b0000, FREE,   32'h108, 32'h0,        10'b1111_00_0_01_0));
        vecs.push_back(mk(4'b1000, 4'b0000, ACCESS, 32'h108, 32'h44444444, 10'b0111_10_1_11_0));
        vecs.push_back(mk(4'b0000, 4'b0000, FREE,   32'h108, 32'h0,        10'b1111_00_1_11_0));
        // all four hold requests: grants 0,1,2,3 with one IDLE cycle between owners
        for (int g = 0; g < NREQ; g++) begin
            logic [3:0] wmask;
            logic [1:0] prev;
            wmask = ~(4'b0001 << g);
            prev  = 2'(g + NREQ - 1);
            vecs.push_back(mk(4'b1111, 4'b0000, FREE,   32'h108, 32'h0, {4'hF, 2'b00, 1'b0, prev, 1'b0}));
            vecs.push_back(mk(4'b1111, 4'b0000, ACCESS, 32'h108, 32'hA0, {wmask, 2'b10, 1'b1, 2'(g), 1'b0}));
            vecs.push_back(mk(4'b1111, 4'b0000, ACCESS, 32'h108, 32'hA0, {wmask, 2'b10, 1'b1, 2'(g), 1'b0}));
        end
        vecs.push_back(mk(4'b1111, 4'b0000, FREE,   32'h108, 32'h0,  10'b1111_00_0_11_0));
        vecs.push_back(mk(4'b1111, 4'b0000, ACCESS, 32'h108, 32'hA0, 10'b1110_10_1_00_0));
        vecs.push_back(mk(4'b0000, 4'b0000, FREE,   32'h108, 32'h0,  10'b1111_00_1_00_0));

        nRST      = 1'b0;
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = {32'h100, 32'h80, 32'h40, 32'h10};
        req_store = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
        ramload   = '0;
        ramstate  = FREE;

        repeat (2) @(negedge CLK);
        #1;
        check("reset ctl", 128'(ctl_now()), 128'(10'b1111_00_0_00_0));
        check("reset bus", 128'({ramaddr, ramstore}), 128'h0);
        check("reset load", 128'(req_load), 128'h0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (vecs[i]) begin
            @(negedge CLK);
            req_ren     = vecs[i].ren;
            req_wen     = vecs[i].wen;
            ramstate    = vecs[i].rs;
            req_addr[3] = vecs[i].a3;
            ramload     = vecs[i].ld;
            #1;
            ec      = vecs[i].ctl;
            gid     = ec[2:1];
            exp_bus = ec[3] ? {req_addr[gid], req_store[gid]} : 64'h0;
            for (int j = 0; j < NREQ; j++)
                exp_load[j] = (!ec[6+j] && req_ren[j] && !req_wen[j]) ? vecs[i].ld : 32'h0;
            check($sformatf("vec%0d ctl", i), 128'(ctl_now()), 128'(ec));
            check($sformatf("vec%0d bus", i), 128'({ramaddr, ramstore}), 128'(exp_bus));
            check($sformatf("vec%0d load", i), 128'(req_load), 128'(exp_load));
        end

        // 2 ages past STARVE while 3 owns a slow word; after release rr_ptr=0 but 2 wins
        step(4'b1000, FREE);
        repeat (9) step(4'b1100, BUSY);
        step(4'b1111, ACCESS);
        step(4'b0111, FREE);
        step(4'b0111, FREE);
        check("starve idle gap", 128'({grant_valid, grant_id}), 128'({1'b0, 2'd3}));
        step(4'b1110, BUSY);
        check("starve grant", 128'({grant_valid, grant_id, ramREN}), 128'({1'b1, 2'd2, 1'b1}));
        // 1 and 3 both starve; rr_ptr=3 after release, lowest starved index wins
        repeat (8) step(4'b1110, BUSY);
        step(4'b1010, FREE);
        step(4'b1010, FREE);
        step(4'b1010, BUSY);
        check("starve tie", 128'({grant_valid, grant_id, ramaddr}), 128'({1'b1, 2'd1, 32'h40}));

        // reset asserted mid-cycle during a BUSY transfer
        check("pre-reset strobe", 128'(ramREN), 128'(1'b1));
        #2 nRST = 1'b0;
        #1;
        check("mid-xfer reset ctl", 128'(ctl_now()), 128'(10'b1111_00_0_00_0));
        check("mid-xfer reset bus", 128'({ramaddr, ramstore}), 128'h0);
        check("mid-xfer reset load", 128'(req_load), 128'h0);
        @(negedge CLK);
        nRST     = 1'b1;
        req_ren  = 4'b1111;
        ramstate = FREE;
        step(4'b1111, BUSY);
        check("post-reset grant", 128'({grant_valid, grant_id, ramREN, ramaddr}),
              128'({1'b1, 2'd0, 1'b1, 32'h10}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
